// File: rtl/pe_array_cfg_scheduler_pkg.sv
// Shared types and defaults for the PE array configuration scheduler.
package pe_array_cfg_scheduler_pkg;

    localparam int DEF_PE_INST_W = 28;
    localparam int DEF_DEPTH     = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4
    } sched_state_e;

    function automatic logic ctx_in_range(input int unsigned n, input int unsigned depth);
        return (n != 0) && (n <= depth);
    endfunction

endpackage

// File: rtl/pe_array_cfg_scheduler_if.sv
// Valid/ready stream carrying PE instruction words from the config DMA.
interface pe_array_cfg_scheduler_if #(
    parameter int PE_INST_W = 28
);
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [PE_INST_W-1:0] cfg_data;

    modport master (output cfg_valid, output cfg_data, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/pe_array_cfg_scheduler.sv
// Clears, loads (context-major, round-robin over PEs) and runs a PE array.
// Every output is a register fed by the next-state logic below.
module pe_array_cfg_scheduler
    import pe_array_cfg_scheduler_pkg::*;
#(
    parameter int NUM_PE    = 16,
    parameter int PE_INST_W = DEF_PE_INST_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int DRAIN     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [$clog2(DEPTH):0]   num_ctx,
    pe_array_cfg_scheduler_if.slave  cfg,
    output logic                     pe_rst,
    output logic [NUM_PE-1:0]        pe_init,
    output logic [PE_INST_W-1:0]     pe_inst,
    output logic                     pe_run,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int CTX_W    = $clog2(DEPTH) + 1;
    localparam int PE_IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int DRN_W    = $clog2(DRAIN + 1);

    sched_state_e         state, state_nxt;
    logic [PE_IDX_W-1:0]  pe_idx, pe_idx_nxt;
    logic [CTX_W-1:0]     ctx_idx, ctx_idx_nxt;
    logic [CTX_W-1:0]     run_cnt, run_cnt_nxt;
    logic [CTX_W-1:0]     num_ctx_q, num_ctx_nxt;
    logic [DRN_W-1:0]     drain_cnt, drain_cnt_nxt;
    logic                 cfg_ready_q, cfg_ready_nxt;
    logic                 pe_rst_nxt, pe_run_nxt, busy_nxt, done_nxt, err_nxt;
    logic [NUM_PE-1:0]    pe_init_nxt;
    logic [PE_INST_W-1:0] pe_inst_nxt;
    logic                 last_word;

    assign cfg.cfg_ready = cfg_ready_q;
    assign last_word = (pe_idx == PE_IDX_W'(NUM_PE - 1)) && (ctx_idx == num_ctx_q - CTX_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pe_idx      <= '0;
            ctx_idx     <= '0;
            run_cnt     <= '0;
            num_ctx_q   <= '0;
            drain_cnt   <= '0;
            cfg_ready_q <= 1'b0;
            pe_rst      <= 1'b0;
            pe_init     <= '0;
            pe_inst     <= '0;
            pe_run      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            pe_idx      <= pe_idx_nxt;
            ctx_idx     <= ctx_idx_nxt;
            run_cnt     <= run_cnt_nxt;
            num_ctx_q   <= num_ctx_nxt;
            drain_cnt   <= drain_cnt_nxt;
            cfg_ready_q <= cfg_ready_nxt;
            pe_rst      <= pe_rst_nxt;
            pe_init     <= pe_init_nxt;
            pe_inst     <= pe_inst_nxt;
            pe_run      <= pe_run_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            err         <= err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pe_idx_nxt    = pe_idx;
        ctx_idx_nxt   = ctx_idx;
        run_cnt_nxt   = run_cnt;
        num_ctx_nxt   = num_ctx_q;
        drain_cnt_nxt = drain_cnt;
        cfg_ready_nxt = cfg_ready_q;
        pe_rst_nxt    = 1'b0;
        pe_init_nxt   = '0;
        pe_inst_nxt   = pe_inst;
        pe_run_nxt    = 1'b0;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;

        // abort wins over everything, including a start in the same cycle
        if (abort) begin
            state_nxt     = S_IDLE;
            cfg_ready_nxt = 1'b0;
            pe_rst_nxt    = 1'b1;
            pe_idx_nxt    = '0;
            ctx_idx_nxt   = '0;
            run_cnt_nxt   = '0;
            drain_cnt_nxt = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (ctx_in_range(32'(num_ctx), DEPTH)) begin
                            num_ctx_nxt = num_ctx;
                            pe_idx_nxt  = '0;
                            ctx_idx_nxt = '0;
                            pe_rst_nxt  = 1'b1;
                            state_nxt   = S_CLR;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end
                end
                S_CLR: begin
                    cfg_ready_nxt = 1'b1;
                    state_nxt     = S_LOAD;
                end
                S_LOAD: begin
                    // ready low inside LOAD means the final init is on the bus now
                    if (cfg_ready_q) begin
                        if (cfg.cfg_valid) begin
                            pe_init_nxt = NUM_PE'(1) << pe_idx;
                            pe_inst_nxt = cfg.cfg_data;
                            if (last_word)
                                cfg_ready_nxt = 1'b0;
                            if (pe_idx == PE_IDX_W'(NUM_PE - 1)) begin
                                pe_idx_nxt  = '0;
                                ctx_idx_nxt = ctx_idx + CTX_W'(1);
                            end else begin
                                pe_idx_nxt = pe_idx + PE_IDX_W'(1);
                            end
                        end
                    end else begin
                        pe_run_nxt  = 1'b1;
                        run_cnt_nxt = CTX_W'(1);
                        state_nxt   = S_RUN;
                    end
                end
                S_RUN: begin
                    if (run_cnt == num_ctx_q) begin
                        drain_cnt_nxt = DRN_W'(1);
                        state_nxt     = S_DRAIN;
                    end else begin
                        pe_run_nxt  = 1'b1;
                        run_cnt_nxt = run_cnt + CTX_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DRN_W'(DRAIN)) begin
                        done_nxt  = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        drain_cnt_nxt = drain_cnt + DRN_W'(1);
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end

        busy_nxt = (state_nxt != S_IDLE);
    end

endmodule

// File: tb/tb_pe_array_cfg_scheduler.sv
// Directed bench for the PE array configuration scheduler with a PE buffer scoreboard.
module tb_pe_array_cfg_scheduler;

    localparam int NUM_PE    = 4;
    localparam int PE_INST_W = 28;
    localparam int DEPTH     = 16;
    localparam int DRAIN     = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic [4:0]           num_ctx = '0;
    logic                 pe_rst;
    logic [NUM_PE-1:0]    pe_init;
    logic [PE_INST_W-1:0] pe_inst;
    logic                 pe_run, busy, done, err;

    pe_array_cfg_scheduler_if #(.PE_INST_W(PE_INST_W)) cfg_if ();

    pe_array_cfg_scheduler #(
        .NUM_PE(NUM_PE), .PE_INST_W(PE_INST_W), .DEPTH(DEPTH), .DRAIN(DRAIN)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .num_ctx(num_ctx),
        .cfg(cfg_if), .pe_rst(pe_rst), .pe_init(pe_init), .pe_inst(pe_inst),
        .pe_run(pe_run), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Cycle-level monitor plus a model of the PE context buffers
    int cyc = 0;
    int rst_cnt = 0, init_cnt = 0, run_cnt = 0, done_cnt = 0, err_cnt = 0, viol_cnt = 0;
    int rst_last = 0, init_rise = 0, init_last = 0, run_rise = 0, run_last = 0, done_last = 0;
    logic init_prev = 1'b0, run_prev = 1'b0;
    logic [NUM_PE-1:0]    log_mask [64];
    logic [PE_INST_W-1:0] log_data [64];
    logic [PE_INST_W-1:0] pbuf [NUM_PE][DEPTH];
    int wptr [NUM_PE];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        init_prev <= |pe_init;
        run_prev  <= pe_run;
        if ((|pe_init && pe_run) || (pe_rst && (|pe_init || pe_run)) || ($countones(pe_init) > 1))
            viol_cnt <= viol_cnt + 1;
        if (pe_rst) begin
            rst_cnt  <= rst_cnt + 1;
            rst_last <= cyc;
            for (int i = 0; i < NUM_PE; i++) wptr[i] <= 0;
        end
        if (|pe_init) begin
            init_cnt  <= init_cnt + 1;
            init_last <= cyc;
            if (!init_prev) init_rise <= cyc;
            if (init_cnt < 64) begin
                log_mask[init_cnt] <= pe_init;
                log_data[init_cnt] <= pe_inst;
            end
            for (int i = 0; i < NUM_PE; i++)
                if (pe_init[i] && wptr[i] < DEPTH) begin
                    pbuf[i][wptr[i]] <= pe_inst;
                    wptr[i] <= wptr[i] + 1;
                end
        end
        if (pe_run) begin
            run_cnt  <= run_cnt + 1;
            run_last <= cyc;
            if (!run_prev) run_rise <= cyc;
        end
        if (done) begin
            done_cnt  <= done_cnt + 1;
            done_last <= cyc;
        end
        if (err) err_cnt <= err_cnt + 1;
    end

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends n words base..base+n-1; gap inserts an idle cycle after every handshake
    task automatic send_words(input int n, input int base, input bit gap, input bit hold_valid);
        for (int k = 0; k < n; k++) begin
            bit hs;
            int w;
            cfg_if.cfg_valid = 1'b1;
            cfg_if.cfg_data  = PE_INST_W'(base + k);
            hs = 1'b0;
            w  = 0;
            while (!hs && w < 20) begin
                hs = cfg_if.cfg_ready;
                tick();
                w++;
            end
            if (!hs) check_val("handshake_timeout", 0, 1);
            if (gap) begin
                cfg_if.cfg_valid = 1'b0;
                tick();
            end
        end
        cfg_if.cfg_valid = hold_valid;
    endtask

    task automatic wait_done();
        int w = 0;
        while (!done && w < 100) begin
            tick();
            w++;
        end
        check_val("done_seen", done, 1);
        tick();
        tick();
    endtask

    task automatic start_job(input int nctx, output int t0);
        num_ctx = 5'(nctx);
        start = 1'b1;
        tick();
        t0 = cyc;
        start = 1'b0;
        num_ctx = 5'd7;
        check_val("busy_after_start", busy, 1);
    endtask

    task automatic check_bufs(input string tag, input int nctx, input int base);
        for (int p = 0; p < NUM_PE; p++) begin
            check_val({tag, "_wptr"}, wptr[p], nctx);
            for (int c = 0; c < nctx; c++)
                check_val({tag, "_buf"}, pbuf[p][c], base + p + NUM_PE * c);
        end
    endtask

    initial begin
        int t0, r0, i0, u0, d0, e0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_data  = '0;

        // Test 1: reset, then idle
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();
        check_val("idle_cfg_ready", cfg_if.cfg_ready, 0);
        check_val("idle_pe_rst", pe_rst, 0);
        check_val("idle_pe_init", pe_init, 0);
        check_val("idle_pe_inst", pe_inst, 0);
        check_val("idle_pe_run", pe_run, 0);
        check_val("idle_busy", busy, 0);
        check_val("idle_done_err", {done, err}, 0);

        // Test 2: back-to-back load, valid already high before LOAD
        r0 = rst_cnt; i0 = init_cnt; u0 = run_cnt; d0 = done_cnt;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_data  = PE_INST_W'(1);
        start_job(2, t0);
        check_val("t2_pe_rst_now", pe_rst, 1);
        send_words(8, 1, 1'b0, 1'b0);
        check_val("t2_ready_dropped", cfg_if.cfg_ready, 0);
        wait_done();
        check_val("t2_rst_pulses", rst_cnt - r0, 1);
        check_val("t2_rst_cyc", rst_last - t0, 0);
        check_val("t2_init_count", init_cnt - i0, 8);
        check_val("t2_init_first", init_rise - t0, 2);
        check_val("t2_init_last", init_last - t0, 9);
        for (int k = 0; k < 8; k++) begin
            check_val("t2_init_mask", log_mask[i0 + k], 1 << (k % NUM_PE));
            check_val("t2_init_data", log_data[i0 + k], k + 1);
        end
        check_val("t2_run_count", run_cnt - u0, 2);
        check_val("t2_run_first", run_rise - t0, 10);
        check_val("t2_run_last", run_last - t0, 11);
        check_val("t2_done_count", done_cnt - d0, 1);
        check_val("t2_done_cyc", done_last - t0, 14);
        check_val("t2_busy_end", busy, 0);
        check_bufs("t2", 2, 1);

        // Test 3: valid toggling every other cycle
        i0 = init_cnt; u0 = run_cnt; d0 = done_cnt;
        start_job(2, t0);
        send_words(8, 1, 1'b1, 1'b0);
        wait_done();
        check_val("t3_init_count", init_cnt - i0, 8);
        check_val("t3_run_count", run_cnt - u0, 2);
        check_val("t3_done_count", done_cnt - d0, 1);
        check_bufs("t3", 2, 1);

        // Test 4: out-of-range num_ctx
        r0 = rst_cnt; e0 = err_cnt;
        for (int j = 0; j < 2; j++) begin
            num_ctx = (j == 0) ? 5'd0 : 5'(DEPTH + 1);
            start = 1'b1;
            tick();
            start = 1'b0;
            check_val("t4_err", err, 1);
            check_val("t4_busy", busy, 0);
            tick();
            check_val("t4_err_pulse", err, 0);
            check_val("t4_busy_after", busy, 0);
        end
        tick();
        check_val("t4_err_count", err_cnt - e0, 2);
        check_val("t4_no_pe_rst", rst_cnt - r0, 0);

        // Test 5: abort after 3 of 8 words, then a fresh job
        r0 = rst_cnt; d0 = done_cnt;
        start_job(2, t0);
        send_words(3, 1, 1'b0, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("t5_busy", busy, 0);
        check_val("t5_pe_rst", pe_rst, 1);
        check_val("t5_cfg_ready", cfg_if.cfg_ready, 0);
        check_val("t5_pe_init", pe_init, 0);
        repeat (6) tick();
        check_val("t5_pe_rst_pulse", pe_rst, 0);
        check_val("t5_rst_count", rst_cnt - r0, 2);
        check_val("t5_no_done", done_cnt - d0, 0);
        check_val("t5_cleared", wptr[0] + wptr[1] + wptr[2] + wptr[3], 0);
        i0 = init_cnt; d0 = done_cnt;
        start_job(2, t0);
        send_words(8, 'h20, 1'b0, 1'b0);
        wait_done();
        check_val("t5_fresh_init", init_cnt - i0, 8);
        check_val("t5_fresh_done", done_cnt - d0, 1);
        check_bufs("t5", 2, 'h20);

        // Test 6: start and cfg_valid asserted during RUN are ignored
        r0 = rst_cnt; i0 = init_cnt; u0 = run_cnt; d0 = done_cnt;
        start_job(3, t0);
        send_words(12, 'h40, 1'b0, 1'b1);
        cfg_if.cfg_data = PE_INST_W'('h7ff);
        for (int w = 0; w < 10 && !pe_run; w++) tick();
        check_val("t6_run_started", pe_run, 1);
        start = 1'b1;
        for (int w = 0; w < 10 && pe_run; w++) tick();
        start = 1'b0;
        wait_done();
        cfg_if.cfg_valid = 1'b0;
        repeat (3) tick();
        check_val("t6_run_count", run_cnt - u0, 3);
        check_val("t6_done_count", done_cnt - d0, 1);
        check_val("t6_init_count", init_cnt - i0, 12);
        check_val("t6_rst_count", rst_cnt - r0, 1);
        check_val("t6_busy_end", busy, 0);
        check_bufs("t6", 3, 'h40);

        check_val("exclusivity_violations", viol_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
